// File: rtl/cc_gate_accum_pkg.sv
// cc_gate_accum_pkg: op encodings and FSM state type shared by the fold block
package cc_gate_accum_pkg;
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} state_t;
endpackage

// File: rtl/cc_gate_logic_unit.sv
// cc_gate_logic_unit: combinational bitwise a OP b, NAND folds as AND
module cc_gate_logic_unit
  import cc_gate_accum_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_y
);
  always_comb o_y = (i_op == OP_OR) ? (i_a | i_b) : (i_op == OP_XOR) ? (i_a ^ i_b) : (i_a & i_b);
endmodule

// File: rtl/cc_gate_accum.sv
// cc_gate_accum: folds FRAME_LEN words with a bitwise op behind valid/ready handshakes
module cc_gate_accum
  import cc_gate_accum_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN = 4,
  localparam int CNT_WIDTH = $clog2(FRAME_LEN + 1)
) (
  input  logic                  cc_gate_accum_CLOCK_50,
  input  logic                  cc_gate_accum_RESET_InHigh,
  input  logic [1:0]            cc_gate_accum_op_In,
  input  logic [DATA_WIDTH-1:0] cc_gate_accum_data_In,
  input  logic                  cc_gate_accum_inValid_In,
  output logic                  cc_gate_accum_inReady_Out,
  output logic [DATA_WIDTH-1:0] cc_gate_accum_result_Out,
  output logic                  cc_gate_accum_outValid_Out,
  input  logic                  cc_gate_accum_outReady_In,
  output logic [CNT_WIDTH-1:0]  cc_gate_accum_count_Out
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_M1 = CNT_WIDTH'(FRAME_LEN - 1);
  state_t r_state, w_next;
  logic [DATA_WIDTH-1:0] r_acc, w_fold;
  logic [1:0] r_op;
  logic [CNT_WIDTH-1:0] r_count;
  logic w_in_fire, w_out_fire;
  cc_gate_logic_unit #(.DATA_WIDTH(DATA_WIDTH)) u_logic (
    .i_op(r_op),
    .i_a (r_acc),
    .i_b (cc_gate_accum_data_In),
    .o_y (w_fold)
  );
  assign cc_gate_accum_inReady_Out  = !cc_gate_accum_RESET_InHigh && r_state != ST_HOLD;
  assign cc_gate_accum_outValid_Out = r_state == ST_HOLD;
  // NAND is folded as AND; the inversion is applied only on the way out
  assign cc_gate_accum_result_Out   = (r_op == OP_NAND) ? ~r_acc : r_acc;
  assign cc_gate_accum_count_Out    = r_count;
  assign w_in_fire  = cc_gate_accum_inValid_In && cc_gate_accum_inReady_Out;
  assign w_out_fire = cc_gate_accum_outValid_Out && cc_gate_accum_outReady_In;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_in_fire) w_next = (FRAME_LEN == 1) ? ST_HOLD : ST_ACCUM;
      ST_ACCUM: if (w_in_fire && r_count == LAST_M1) w_next = ST_HOLD;
      ST_HOLD:  if (cc_gate_accum_outReady_In) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge cc_gate_accum_CLOCK_50) begin
    if (cc_gate_accum_RESET_InHigh) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_op    <= OP_AND;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_in_fire && r_state == ST_IDLE) begin
        r_acc   <= cc_gate_accum_data_In;
        r_op    <= cc_gate_accum_op_In;
        r_count <= CNT_WIDTH'(1);
      end else if (w_in_fire) begin
        r_acc   <= w_fold;
        r_count <= (r_count == LAST) ? LAST : r_count + 1'b1;
      end else if (w_out_fire) begin
        r_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cc_gate_accum.sv
// tb_cc_gate_accum: directed and random frames checked against a frame-level fold model
module tb_cc_gate_accum;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [1:0] op_a;
  logic [7:0] data_a, res_a;
  logic iv_a, ir_a, ov_a, or_a;
  logic [2:0] cnt_a;
  logic [1:0] op_b;
  logic [15:0] data_b, res_b;
  logic iv_b, ir_b, ov_b, or_b;
  logic [0:0] cnt_b;
  int checks = 0, errors = 0;
  cc_gate_accum dut_a (
    .cc_gate_accum_CLOCK_50(clk), .cc_gate_accum_RESET_InHigh(rst),
    .cc_gate_accum_op_In(op_a), .cc_gate_accum_data_In(data_a),
    .cc_gate_accum_inValid_In(iv_a), .cc_gate_accum_inReady_Out(ir_a),
    .cc_gate_accum_result_Out(res_a), .cc_gate_accum_outValid_Out(ov_a),
    .cc_gate_accum_outReady_In(or_a), .cc_gate_accum_count_Out(cnt_a)
  );
  cc_gate_accum #(.DATA_WIDTH(16), .FRAME_LEN(1)) dut_b (
    .cc_gate_accum_CLOCK_50(clk), .cc_gate_accum_RESET_InHigh(rst),
    .cc_gate_accum_op_In(op_b), .cc_gate_accum_data_In(data_b),
    .cc_gate_accum_inValid_In(iv_b), .cc_gate_accum_inReady_Out(ir_b),
    .cc_gate_accum_result_Out(res_b), .cc_gate_accum_outValid_Out(ov_b),
    .cc_gate_accum_outReady_In(or_b), .cc_gate_accum_count_Out(cnt_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] fold(input logic [1:0] op, input logic [31:0] q[$], input int w);
    logic [31:0] acc = q[0];
    for (int i = 1; i < q.size(); i++)
      acc = (op == 2'b01) ? (acc | q[i]) : (op == 2'b10) ? (acc ^ q[i]) : (acc & q[i]);
    if (op == 2'b11) acc = ~acc;
    return acc & ((32'h1 << w) - 1);
  endfunction
  task automatic frame_a(input logic [1:0] op0, input logic [1:0] op_rest, input logic [7:0] w0, w1, w2, w3,
                         input int gap, input int hold);
    logic [31:0] q[$];
    logic [31:0] exp;
    q.push_back(w0); q.push_back(w1); q.push_back(w2); q.push_back(w3);
    exp = fold(op0, q, 8);
    for (int i = 0; i < 4; i++) begin
      iv_a = 0;
      data_a = 8'($urandom);
      repeat (gap) begin
        @(posedge clk); #1;
        chk("a_gap_count", 32'(cnt_a), 32'(i));
      end
      iv_a = 1; data_a = q[i][7:0]; op_a = (i == 0) ? op0 : op_rest;
      chk("a_in_ready", 32'(ir_a), 1);
      chk("a_no_early_valid", 32'(ov_a), 0);
      @(posedge clk); #1;
      chk("a_count", 32'(cnt_a), 32'(i + 1));
    end
    chk("a_out_valid", 32'(ov_a), 1);
    chk("a_result", 32'(res_a), exp);
    chk("a_hold_in_ready", 32'(ir_a), 0);
    iv_a = 1; data_a = 8'h55; op_a = 2'($urandom);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("a_bp_valid", 32'(ov_a), 1);
      chk("a_bp_result", 32'(res_a), exp);
      chk("a_bp_in_ready", 32'(ir_a), 0);
      chk("a_bp_count", 32'(cnt_a), 4);
    end
    iv_a = 0; or_a = 1;
    @(posedge clk); #1;
    or_a = 0;
    chk("a_post_valid", 32'(ov_a), 0);
    chk("a_post_in_ready", 32'(ir_a), 1);
    chk("a_post_count", 32'(cnt_a), 0);
  endtask
  initial begin
    logic [31:0] q[$];
    logic [15:0] wb;
    logic [1:0] ob;
    op_a = 0; data_a = 0; iv_a = 0; or_a = 0;
    op_b = 0; data_b = 0; iv_b = 0; or_b = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ir_a), 0);
    chk("rst_valid", 32'(ov_a), 0);
    chk("rst_result", 32'(res_a), 0);
    chk("rst_count", 32'(cnt_a), 0);
    rst = 0; #1;
    chk("rel_in_ready", 32'(ir_a), 1);
    frame_a(2'b00, 2'b00, 8'hFF, 8'hF3, 8'h7F, 8'h3E, 0, 0);
    chk("and_const", 32'(fold(2'b00, '{32'hFF, 32'hF3, 32'h7F, 32'h3E}, 8)), 32'h32);
    frame_a(2'b10, 2'b10, 8'h01, 8'h02, 8'h04, 8'h08, 2, 0);
    frame_a(2'b01, 2'b01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 5);
    frame_a(2'b11, 2'b01, 8'hAA, 8'hFF, 8'hAA, 8'hAA, 0, 0);
    iv_a = 1; op_a = 2'b00;
    repeat (2) begin
      data_a = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("mid_count", 32'(cnt_a), 2);
    rst = 1; iv_a = 0; #1;
    chk("mid_rst_in_ready", 32'(ir_a), 0);
    @(posedge clk); #1;
    chk("mid_rst_count", 32'(cnt_a), 0);
    chk("mid_rst_valid", 32'(ov_a), 0);
    chk("mid_rst_result", 32'(res_a), 0);
    rst = 0; #1;
    frame_a(2'b01, 2'b01, 8'h01, 8'h02, 8'h04, 8'h08, 0, 0);
    repeat (20)
      frame_a(2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 3));
    op_b = 2'b10; iv_b = 1; data_b = 16'h1234;
    chk("b_ready0", 32'(ir_b), 1);
    @(posedge clk); #1;
    chk("b_res0", 32'(res_b), 32'h1234);
    chk("b_valid0", 32'(ov_b), 1);
    chk("b_ready1", 32'(ir_b), 0);
    chk("b_count0", 32'(cnt_b), 1);
    data_b = 16'hABCD;
    @(posedge clk); #1;
    chk("b_ready2", 32'(ir_b), 1);
    chk("b_valid1", 32'(ov_b), 0);
    @(posedge clk); #1;
    chk("b_res1", 32'(res_b), 32'hABCD);
    chk("b_ready3", 32'(ir_b), 0);
    @(posedge clk); #1;
    repeat (10) begin
      wb = 16'($urandom); ob = 2'($urandom);
      q = {};
      q.push_back(32'(wb));
      op_b = ob; data_b = wb;
      chk("b_rnd_ready", 32'(ir_b), 1);
      @(posedge clk); #1;
      chk("b_rnd_res", 32'(res_b), fold(ob, q, 16));
      chk("b_rnd_valid", 32'(ov_b), 1);
      @(posedge clk); #1;
      chk("b_rnd_done", 32'(ov_b), 0);
    end
    iv_b = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
